// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Summary  : Queues note commands and drives the DDS tune word and volume.
//            Volume ramps linearly so that the tune word only changes at zero
//            volume. Define NOTE_SEQ_LEGATO_EN for direct note-to-note glides.
// Revision : 1.0  initial release
// ============================================================================
module note_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int RAMP_STEP  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        cmd_valid,
    input  logic [15:0]                 cmd_tune,
    input  logic [7:0]                  cmd_vol,
    input  logic [15:0]                 cmd_dur,
    input  logic                        stop,
    output logic                        cmd_ready,
    output logic [15:0]                 tuneWord,
    output logic [7:0]                  volume,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int              c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [8:0]      c_STEP    = 9'(RAMP_STEP);
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic [39:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [15:0]     r_tune;
    logic [7:0]      r_volume;
    logic [7:0]      r_target;
    logic [15:0]     r_dur_cnt;

    logic        w_push;
    logic        w_pop;
    logic        w_pop_idle;
    logic        w_pop_legato;
    logic        w_empty;
    logic [39:0] w_head;
    logic [8:0]  w_up;
    logic [7:0]  w_vol_up;
    logic [7:0]  w_vol_dn;
    logic [7:0]  w_vol_attack;

    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // stop wins over a coincident push; full-queue pushes are dropped via cmd_ready
    assign w_push     = cmd_valid && cmd_ready && !stop;
    assign w_pop_idle = tick && !stop && !w_empty && (r_state == S_IDLE);

    // Saturating ramp arithmetic: up clamps at target, down clamps at zero
    assign w_up     = {1'b0, r_volume} + c_STEP;
    assign w_vol_up = (w_up > {1'b0, r_target}) ? r_target : w_up[7:0];
    assign w_vol_dn = ({1'b0, r_volume} >= c_STEP) ? (r_volume - c_STEP[7:0]) : 8'd0;

`ifdef NOTE_SEQ_LEGATO_EN
    logic [7:0] w_vol_dn_tgt;
    assign w_vol_dn_tgt = (w_vol_dn < r_target) ? r_target : w_vol_dn;
    assign w_pop_legato = tick && !stop && !w_empty &&
                          (r_state == S_SUSTAIN) && (r_dur_cnt == 16'd0);
    assign w_vol_attack = (r_volume > r_target) ? w_vol_dn_tgt : w_vol_up;
`else
    assign w_pop_legato = 1'b0;
    assign w_vol_attack = w_vol_up;
`endif

    assign w_pop = w_pop_idle || w_pop_legato;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_tune, cmd_vol, cmd_dur};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tune    <= 16'd0;
            r_volume  <= 8'd0;
            r_target  <= 8'd0;
            r_dur_cnt <= 16'd0;
        end else if (stop && (r_state == S_ATTACK || r_state == S_SUSTAIN)) begin
            r_state <= S_RELEASE;
        end else if (tick) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tune    <= w_head[39:24];
                        r_target  <= w_head[23:16];
                        r_dur_cnt <= w_head[15:0];
                        r_state   <= S_ATTACK;
                    end
                end
                S_ATTACK: begin
                    if (r_volume == r_target) r_state  <= S_SUSTAIN;
                    else                      r_volume <= w_vol_attack;
                end
                S_SUSTAIN: begin
                    if (r_dur_cnt != 16'd0) begin
                        r_dur_cnt <= r_dur_cnt - 16'd1;
                    end else if (w_pop) begin
                        r_tune    <= w_head[39:24];
                        r_target  <= w_head[23:16];
                        r_dur_cnt <= w_head[15:0];
                        r_state   <= S_ATTACK;
                    end else begin
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (r_volume == 8'd0) r_state  <= S_IDLE;
                    else                  r_volume <= w_vol_dn;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (r_count < c_DEPTH);
    assign tuneWord   = r_tune;
    assign volume     = r_volume;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Schedules notes into the tone datapath: queues note commands (tune word, target volume, duration) and drives the DDS tune word and volume inputs.
- Applies a linear attack/release volume ramp so tune-word changes only happen at zero volume, which prevents clicks.
- Sits between the SPI command receiver and the wave generator / PWM stage.
- All timing advances on `tick`, the 156.25 kHz wave-generator enable pulse (clk/256).

Parameters:
- FIFO_DEPTH, 8: note command queue depth (power of 2, ≥2).
- RAMP_STEP, 1: volume LSBs added or removed per tick during attack and release.

Ports:
- clk  in  1  system clock (40 MHz)
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk pulse per wave-gen sample; all state timing advances only on tick cycles
- cmd_valid  in  1  push request for a note command
- cmd_tune  in  16  DDS tune word for the note
- cmd_vol  in  8  sustain volume target
- cmd_dur  in  16  sustain length in ticks (sustain lasts cmd_dur+1 ticks)
- stop  in  1  one-clk pulse: flush the queue and release the current note
- cmd_ready  out  1  queue not full (registered count < FIFO_DEPTH)
- tuneWord  out  16  tune word to the wave generator
- volume  out  8  volume to the output multiplier
- busy  out  1  state != IDLE or queue non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued

Behaviour:
- Reset (synchronous, active-high): state IDLE, queue emptied, tuneWord=0, volume=0, cmd_ready=1, busy=0, fifo_count=0. Reset mid-note forces volume to 0 on the next edge; no ramp.
- Push: a push occurs when cmd_valid && cmd_ready. cmd_ready comes from the registered count only. A push while full is dropped, even if a pop happens in the same cycle.
- Pop: push and pop in the same cycle leave count unchanged. The queue is FIFO-ordered.
- State machine; all transitions happen only on tick=1 cycles:
  - IDLE: if the queue is non-empty, pop the head, then tuneWord<=cmd_tune, target<=cmd_vol, dur_cnt<=cmd_dur, and go to ATTACK. volume stays 0.
  - ATTACK: if volume==target, go to SUSTAIN. Otherwise volume<=min(volume+RAMP_STEP, target), computed 9-bit with no wrap.
  - SUSTAIN: if dur_cnt==0, go to RELEASE. Otherwise dur_cnt<=dur_cnt-1.
  - RELEASE: if volume==0, go to IDLE. Otherwise volume<=max(volume-RAMP_STEP, 0), with no underflow.
- Latency: a command pushed into an empty queue while IDLE is popped on the first subsequent tick. The first volume step occurs on the following tick.
- cmd_vol=0: ATTACK exits on its first tick; SUSTAIN still runs dur+1 ticks with volume=0.
- Back-to-back notes: IDLE is visited for one tick between notes (release → idle → attack). tuneWord changes only while volume==0.
- stop:
  - Clears the queue on the same edge.
  - If in ATTACK or SUSTAIN, the state becomes RELEASE on the same edge, regardless of tick.
  - stop takes priority over a simultaneous push; that push is dropped.
  - stop while IDLE or RELEASE only flushes the queue.
- tick and cmd/stop may coincide; the queue update and the state update use the same edge.
- All outputs are registered. volume is never greater than target and never wraps.

Optional Feature:
- Macro: NOTE_SEQ_LEGATO_EN.
- Defined:
  - In SUSTAIN, when dur_cnt==0 on a tick and the queue is non-empty, pop directly: tuneWord<=new tune, target<=new vol, dur_cnt<=new dur, state→ATTACK.
  - The ramp in ATTACK becomes bidirectional, stepping by RAMP_STEP toward target and saturating at target. There is no release and no IDLE gap.
  - stop behaviour is unchanged.
- Undefined: behaviour exactly as specified above; ATTACK ramps upward only.

Test Plan:
1. Reset, push {tune=0x0400, vol=4, dur=2}, RAMP_STEP=1 → sequence over the ticks after the pop:
   - volume 1,2,3,4;
   - 3 ticks at SUSTAIN;
   - volume 3,2,1,0;
   - IDLE, busy=0;
   - tuneWord=0x0400 throughout.
2. Push FIFO_DEPTH+1 commands without any tick → cmd_ready=0 after 8 pushes, the 9th is dropped, fifo_count=8. Then exactly 8 notes play in push order.
3. Full queue, push and pop in the same cycle → push dropped, fifo_count=7.
4. stop mid-SUSTAIN with 3 queued notes and volume=200 → fifo_count=0 next edge, state RELEASE, volume ramps to 0, no further notes.
5. cmd_vol=0, dur=0 → ATTACK one tick, SUSTAIN one tick, RELEASE one tick, IDLE; volume stays 0.
6. Reset asserted mid-ATTACK at volume=50 → volume=0, queue empty, tuneWord=0 next edge. With NOTE_SEQ_LEGATO_EN: note vol 100 followed by vol 40 → volume ramps 100→40 without touching 0; tuneWord switches at the sustain end.
